// File: rtl/xbus_lsu_pkg.sv
// Shared types and helpers for the xbus load/store initiator.
package xbus_lsu_pkg;

   localparam int unsigned BYTEW = 8;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_RSV = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StBeat0 = 2'b01,
      StBeat1 = 2'b10,
      StResp  = 2'b11
   } state_e;

   function automatic logic [3:0] size_mask(input size_e sz);
      case (sz)
         SZ_B:    return 4'b0001;
         SZ_H:    return 4'b0011;
         SZ_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
      case (sz)
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/xbus_lsu_if.sv
// Core request/response and xbus beat signals; master is the LSU, slave is the core/bus side.
interface xbus_lsu_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              xbus_cs;
   logic              xbus_we;
   logic [3:0]        xbus_be;
   logic [ADDR_W-1:0] xbus_addr;
   logic [31:0]       xbus_wdata;
   logic [31:0]       xbus_rdata;

   modport master (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, xbus_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata
   );

   modport slave (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, xbus_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata
   );

endinterface

// File: rtl/xbus_lsu_align.sv
// Byte-lane alignment: 64-bit write vector and two-word byte mask from size/offset,
// plus load-data extraction and sign/zero extension.
module xbus_lsu_align
   import xbus_lsu_pkg::*;
(
   input  size_e       size_i,
   input  logic [1:0]  off_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_lo_i,
   input  logic [31:0] rdata_hi_i,
   output logic [63:0] wvec_o,
   output logic [7:0]  mask_o,
   output logic [31:0] rdata_o
);

   logic [5:0]  shamt;
   logic [31:0] rvec;
   logic        sext;

   always_comb begin
      shamt   = 6'(32'(off_i) * BYTEW);
      wvec_o  = {32'b0, wdata_i} << shamt;
      mask_o  = {4'b0, size_mask(size_i)} << off_i;
      rvec    = 32'({rdata_hi_i, rdata_lo_i} >> shamt);
      rdata_o = '0;
      sext    = 1'b0;
      case (size_i)
         SZ_B: begin
            sext    = ~uns_i & rvec[7];
            rdata_o = {{24{sext}}, rvec[7:0]};
         end
         SZ_H: begin
            sext    = ~uns_i & rvec[15];
            rdata_o = {{16{sext}}, rvec[15:0]};
         end
         SZ_W:    rdata_o = rvec;
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/xbus_lsu.sv
// xbus load/store initiator: one request at a time, one or two beats, one-cycle response.
// XBUS_LSU_MISALIGN_SPLIT_EN enables two-beat misaligned access; otherwise misaligned is an error.
module xbus_lsu #(
   parameter int unsigned ADDR_W = 32
) (
   input logic        clk,
   input logic        rst,
   xbus_lsu_if.master bus
);
   import xbus_lsu_pkg::*;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   size_e             size_q, size_d;
   logic              uns_q, uns_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata0_q, rdata0_d;
   logic [31:0]       rdata_hi;

   logic              req_err;
   logic              accept;
   logic [63:0]       wvec;
   logic [7:0]        mask;
   logic [31:0]       ext_rdata;

`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
   logic [31:0]       rdata1_q, rdata1_d;

   assign req_err  = (bus.req_size == SZ_RSV);
   assign rdata_hi = rdata1_q;
`else
   logic              unused_hi;

   assign req_err   = (bus.req_size == SZ_RSV) ||
                      is_misaligned(size_e'(bus.req_size), bus.req_addr[1:0]);
   assign rdata_hi  = 32'b0;
   assign unused_hi = ^{wvec[63:32], mask[7:4]};
`endif

   xbus_lsu_align u_align (
      .size_i     (size_q),
      .off_i      (off_q),
      .uns_i      (uns_q),
      .wdata_i    (wdata_q),
      .rdata_lo_i (rdata0_q),
      .rdata_hi_i (rdata_hi),
      .wvec_o     (wvec),
      .mask_o     (mask),
      .rdata_o    (ext_rdata)
   );

   assign bus.req_ready = (state_q == StIdle) && !rst;
   assign accept        = bus.req_valid && bus.req_ready;

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      size_d   = size_q;
      uns_d    = uns_q;
      err_d    = err_q;
      waddr_d  = waddr_q;
      off_d    = off_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
      rdata1_d = rdata1_q;
`endif
      case (state_q)
         StIdle: begin
            if (accept) begin
               we_d     = bus.req_we;
               size_d   = size_e'(bus.req_size);
               uns_d    = bus.req_unsigned;
               err_d    = req_err;
               waddr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
               off_d    = bus.req_addr[1:0];
               wdata_d  = bus.req_wdata;
               rdata0_d = '0;
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
               rdata1_d = '0;
`endif
               state_d  = req_err ? StResp : StBeat0;
            end
         end
         StBeat0: begin
            rdata0_d = bus.xbus_rdata;
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
            state_d  = (mask[7:4] != 4'b0) ? StBeat1 : StResp;
`else
            state_d  = StResp;
`endif
         end
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
         StBeat1: begin
            rdata1_d = bus.xbus_rdata;
            state_d  = StResp;
         end
`endif
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Every output is gated by !rst so an aborted beat never commits on the reset edge.
   always_comb begin
      bus.xbus_cs    = 1'b0;
      bus.xbus_we    = 1'b0;
      bus.xbus_be    = '0;
      bus.xbus_addr  = '0;
      bus.xbus_wdata = '0;
      bus.resp_valid = 1'b0;
      bus.resp_err   = 1'b0;
      bus.resp_rdata = '0;
      if (!rst) begin
         case (state_q)
            StBeat0: begin
               bus.xbus_cs    = 1'b1;
               bus.xbus_we    = we_q;
               bus.xbus_be    = mask[3:0];
               bus.xbus_addr  = waddr_q;
               bus.xbus_wdata = wvec[31:0];
            end
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
            StBeat1: begin
               bus.xbus_cs    = 1'b1;
               bus.xbus_we    = we_q;
               bus.xbus_be    = mask[7:4];
               bus.xbus_addr  = waddr_q + ADDR_W'(4);
               bus.xbus_wdata = wvec[63:32];
            end
`endif
            StResp: begin
               bus.resp_valid = 1'b1;
               bus.resp_err   = err_q;
               bus.resp_rdata = (we_q || err_q) ? 32'b0 : ext_rdata;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         size_q   <= SZ_B;
         uns_q    <= 1'b0;
         err_q    <= 1'b0;
         waddr_q  <= '0;
         off_q    <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
         rdata1_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         err_q    <= err_d;
         waddr_q  <= waddr_d;
         off_q    <= off_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
         rdata1_q <= rdata1_d;
`endif
      end
   end

endmodule

// File: tb/tb_xbus_lsu.sv
// Directed self-checking bench for xbus_lsu with a byte-enabled word memory model.
module tb_xbus_lsu;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   xbus_lsu_if #(.ADDR_W(32)) bus ();

   xbus_lsu #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory model indexed by addr[11:2]; all test addresses map to distinct entries.
   logic [31:0] mem [1024];
   logic        pl_en;
   logic [9:0]  pl_idx;
   logic [31:0] pl_data;

   assign bus.xbus_rdata = bus.xbus_cs ? mem[bus.xbus_addr[11:2]] : 32'h0;

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_idx] <= pl_data;
      end else if (bus.xbus_cs && bus.xbus_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.xbus_be[b]) mem[bus.xbus_addr[11:2]][b*8 +: 8] <= bus.xbus_wdata[b*8 +: 8];
         end
      end
   end

   int n_checks;
   int n_fail;

   // Per-cycle observations after the accept edge, index c = cycle k+c.
   logic [31:0] o_cs    [1:4];
   logic [31:0] o_we    [1:4];
   logic [31:0] o_be    [1:4];
   logic [31:0] o_addr  [1:4];
   logic [31:0] o_wdata [1:4];
   logic [31:0] o_rv    [1:4];
   logic [31:0] o_rdata [1:4];
   logic [31:0] o_err   [1:4];
   logic [31:0] o_rdy   [1:4];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_idx  = addr[11:2];
      pl_data = data;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      check_eq("ready_before_req", 32'(bus.req_ready), 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         o_cs[c]    = 32'(bus.xbus_cs);
         o_we[c]    = 32'(bus.xbus_we);
         o_be[c]    = 32'(bus.xbus_be);
         o_addr[c]  = bus.xbus_addr;
         o_wdata[c] = bus.xbus_wdata;
         o_rv[c]    = 32'(bus.resp_valid);
         o_rdata[c] = bus.resp_rdata;
         o_err[c]   = 32'(bus.resp_err);
         o_rdy[c]   = 32'(bus.req_ready);
      end
   endtask

   int rv_seen;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      pl_en    = 1'b0;
      pl_idx   = '0;
      pl_data  = '0;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;

      repeat (2) @(negedge clk);
      check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
      check_eq("rst_cs", 32'(bus.xbus_cs), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_ready", 32'(bus.req_ready), 32'd1);
      check_eq("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_eq("idle_resp_rdata", bus.resp_rdata, 32'd0);
      check_eq("idle_xbus_addr", bus.xbus_addr, 32'd0);

      // Aligned word store then load
      run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678);
      check_eq("sw_cs", o_cs[1], 32'd1);
      check_eq("sw_we", o_we[1], 32'd1);
      check_eq("sw_be", o_be[1], 32'hF);
      check_eq("sw_addr", o_addr[1], 32'h100);
      check_eq("sw_wdata", o_wdata[1], 32'h12345678);
      check_eq("sw_ready_busy", o_rdy[1], 32'd0);
      check_eq("sw_no_beat2", o_cs[2], 32'd0);
      check_eq("sw_rv", o_rv[2], 32'd1);
      check_eq("sw_rdata", o_rdata[2], 32'd0);
      check_eq("sw_err", o_err[2], 32'd0);
      check_eq("sw_rv_once", o_rv[3], 32'd0);
      check_eq("sw_ready_after", o_rdy[3], 32'd1);
      check_eq("sw_mem", mem[10'h40], 32'h12345678);

      run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      check_eq("lw_we", o_we[1], 32'd0);
      check_eq("lw_rv_early", o_rv[1], 32'd0);
      check_eq("lw_rv", o_rv[2], 32'd1);
      check_eq("lw_rdata", o_rdata[2], 32'h12345678);
      check_eq("lw_err", o_err[2], 32'd0);

      // Sub-word loads and a byte store
      preload(32'h200, 32'h8899AABB);
      run_req(1'b0, 2'b00, 1'b0, 32'h201, 32'h0);
      check_eq("lb_be", o_be[1], 32'b0010);
      check_eq("lb_rdata", o_rdata[2], 32'hFFFFFFAA);
      run_req(1'b0, 2'b00, 1'b1, 32'h201, 32'h0);
      check_eq("lbu_rdata", o_rdata[2], 32'h000000AA);
      run_req(1'b0, 2'b01, 1'b0, 32'h202, 32'h0);
      check_eq("lh_be", o_be[1], 32'b1100);
      check_eq("lh_rdata", o_rdata[2], 32'hFFFF8899);
      run_req(1'b1, 2'b00, 1'b0, 32'h203, 32'h0000005A);
      check_eq("sb_be", o_be[1], 32'b1000);
      check_eq("sb_lane", 32'(o_wdata[1][31:24]), 32'h5A);
      check_eq("sb_mem", mem[10'h80], 32'h5A99AABB);

`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
      preload(32'h300, 32'h33221100);
      preload(32'h304, 32'h77665544);
      run_req(1'b0, 2'b10, 1'b0, 32'h303, 32'h0);
      check_eq("slw_addr0", o_addr[1], 32'h300);
      check_eq("slw_be0", o_be[1], 32'b1000);
      check_eq("slw_cs1", o_cs[2], 32'd1);
      check_eq("slw_addr1", o_addr[2], 32'h304);
      check_eq("slw_be1", o_be[2], 32'b0111);
      check_eq("slw_rv_early", o_rv[2], 32'd0);
      check_eq("slw_rv", o_rv[3], 32'd1);
      check_eq("slw_rdata", o_rdata[3], 32'h66554433);
      run_req(1'b1, 2'b01, 1'b0, 32'h303, 32'h0000BEEF);
      check_eq("ssh_be0", o_be[1], 32'b1000);
      check_eq("ssh_be1", o_be[2], 32'b0001);
      check_eq("ssh_mem0", mem[10'hC0], 32'hEF221100);
      check_eq("ssh_mem1", mem[10'hC1], 32'h776655BE);
      run_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
      check_eq("wrap_addr0", o_addr[1], 32'hFFFFFFFC);
      check_eq("wrap_be0", o_be[1], 32'b1100);
      check_eq("wrap_addr1", o_addr[2], 32'h00000000);
      check_eq("wrap_be1", o_be[2], 32'b0011);
`else
      run_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
      check_eq("mis_lw_cs", o_cs[1], 32'd0);
      check_eq("mis_lw_rv", o_rv[1], 32'd1);
      check_eq("mis_lw_err", o_err[1], 32'd1);
      check_eq("mis_lw_rdata", o_rdata[1], 32'd0);
      check_eq("mis_lw_rv_once", o_rv[2], 32'd0);
      preload(32'h300, 32'h33221100);
      run_req(1'b1, 2'b01, 1'b0, 32'h303, 32'h0000BEEF);
      check_eq("mis_sh_cs", o_cs[1], 32'd0);
      check_eq("mis_sh_err", o_err[1], 32'd1);
      check_eq("mis_sh_mem", mem[10'hC0], 32'h33221100);
`endif

      // Reserved size
      run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
      check_eq("rsv_cs", o_cs[1], 32'd0);
      check_eq("rsv_rv", o_rv[1], 32'd1);
      check_eq("rsv_err", o_err[1], 32'd1);
      check_eq("rsv_rdata", o_rdata[1], 32'd0);

      // Reset during BEAT0 of a word store aborts it
      preload(32'h400, 32'h11111111);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 32'h400;
      bus.req_wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq("abort_cs", 32'(bus.xbus_cs), 32'd0);
      check_eq("abort_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rv_seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (bus.resp_valid) rv_seen++;
         @(negedge clk);
      end
      check_eq("abort_no_resp", 32'(rv_seen), 32'd0);
      check_eq("abort_ready_after", 32'(bus.req_ready), 32'd1);
      check_eq("abort_mem", mem[10'h100], 32'h11111111);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
